hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the D-stage operand forwarding network: stalls, bubbles and flushes F/D/E/M.
//  Covers load-use hazards the bypass cannot cover, multi-cycle MDU ops held in E, and E-stage branch redirects.
//  Sits beside fwd; consumes the same D/DD register tags and drives the pipeline-register stall/bubble controls.
// PARAMETERS
//  MDU_TIMEOUT  64  max cycles in MDU_WAIT before mdu_timeout_o fires (>=2)
//  CNT_W        32  width of each perf counter (HAZARD_PERF_EN only)
// PORTS
//  clk_i            in   1   clock; all state on rising edge
//  rst_i            in   1   synchronous reset, active-high
//  D_rs1_i          in   5   rs1 of instruction in D
//  D_rs2_i          in   5   rs2 of instruction in D
//  D_use_rs1_i      in   1   D instruction reads rs1
//  D_use_rs2_i      in   1   D instruction reads rs2
//  DD_need_dstE_i   in   1   instruction in E writes a register
//  DD_dstE_i        in   5   its destination
//  DD_sel_reg_i     in   1   1 = result from ALU (valE); 0 = load (valM, not ready in E)
//  E_valid_i        in   1   E holds a real (non-bubble) instruction
//  E_mdu_start_i    in   1   E instruction is a multi-cycle mul/div, first cycle
//  mdu_done_i       in   1   MDU result valid this cycle
//  E_redirect_i     in   1   branch/jump in E resolved taken/mispredicted
//  F_stall_o        out  1   hold PC
//  D_stall_o        out  1   hold F->D register
//  D_bubble_o       out  1   load NOP into F->D register
//  E_stall_o        out  1   hold D->E register
//  E_bubble_o       out  1   load NOP into D->E register
//  M_bubble_o       out  1   load NOP into E->M register
//  mdu_timeout_o    out  1   one-cycle pulse when MDU wait hits MDU_TIMEOUT
//  perf_ldu_o       out  CNT_W  load-use stall count (HAZARD_PERF_EN only)
//  perf_mdu_o       out  CNT_W  MDU stall cycles (HAZARD_PERF_EN only)
//  perf_flush_o     out  CNT_W  redirect flush count (HAZARD_PERF_EN only)
// BEHAVIOUR
//  FSM states: RUN, MDU_WAIT. Reset -> RUN, wait counter 0.
//  While rst_i=1: D_bubble_o=E_bubble_o=M_bubble_o=1; all stalls 0; mdu_timeout_o 0.
//  Control outputs are combinational from state + inputs (same-cycle effect).
//  ldu = DD_need_dstE_i & ~DD_sel_reg_i & E_valid_i & ((D_use_rs1_i & D_rs1_i!=0 & D_rs1_i==DD_dstE_i)
//        | (D_use_rs2_i & D_rs2_i!=0 & D_rs2_i==DD_dstE_i)).
//  Priority per cycle in RUN: mdu_start > redirect > ldu > none.
//  - RUN & E_valid_i & E_mdu_start_i: F/D/E stall, M bubble; next MDU_WAIT, cnt<=1.
//     If mdu_done_i same cycle (1-cycle op): no stall, stay RUN.
//  - RUN & E_redirect_i: D_bubble, E_bubble; no stalls (PC redirect owned by fetch). ldu ignored.
//  - RUN & ldu: F/D stall, E bubble, exactly 1 cycle; next cycle the load is in M and fwd supplies M_valM.
//  - MDU_WAIT: F/D/E stall, M bubble, cnt++. mdu_done_i -> no stall that cycle, release E into M, next RUN.
//     redirect and ldu ignored in MDU_WAIT.
//     cnt==MDU_TIMEOUT & ~mdu_done_i: pulse mdu_timeout_o, release as if done, next RUN.
//  Reset mid-MDU_WAIT: RUN next edge, cnt cleared, no timeout pulse.
//  rd/rs==x0 never causes a hazard.
// CONFIGURATION
//  HAZARD_PERF_EN defined: three CNT_W saturating counters (stop at all-ones), cleared by rst_i;
//   ldu +1 per load-use stall; mdu +1 per stalled MDU cycle; flush +1 per honoured redirect.
//  Undefined: perf_*_o ports absent; no counter logic.
// STRUCTURE
//  define.v: state encodings HZ_RUN/HZ_MDU_WAIT; reuses `XLEN not needed here.
//  Sub-module hazard_perf_cnt (one saturating counter, CNT_W, inc_i), instantiated 3x under HAZARD_PERF_EN.
// TESTING
//  Load x5 in E (sel_reg=0), D add uses rs1=x5 -> 1 cycle F/D stall + E bubble, then clean; rs1=x0 -> no stall.
//  E_mdu_start, mdu_done after 4 cycles -> F/D/E stall + M bubble for exactly 4 cycles, RUN on 5th.
//  Redirect and ldu same cycle -> D/E bubble only, no stall; perf_flush=1, perf_ldu=0.
//  mdu_done never (MDU_TIMEOUT=8) -> mdu_timeout_o single pulse at cnt 8, then RUN.
//  rst_i during MDU_WAIT -> bubbles=1, stalls=0, RUN after; counters 0.
//  HAZARD_PERF_EN, CNT_W=4, 20 load-use events -> perf_ldu_o saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
// FSM state encodings and per-cycle stall/bubble control bundles.
package hazard_ctrl_pkg;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MDU_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_stall;
        logic e_bubble;
        logic m_bubble;
    } hz_ctrl_t;

    // Bit order: f_stall d_stall d_bubble e_stall e_bubble m_bubble
    localparam hz_ctrl_t HZ_NONE  = hz_ctrl_t'(6'b000000);
    localparam hz_ctrl_t HZ_RESET = hz_ctrl_t'(6'b001011);
    localparam hz_ctrl_t HZ_FLUSH = hz_ctrl_t'(6'b001010);
    localparam hz_ctrl_t HZ_LDU   = hz_ctrl_t'(6'b110010);
    localparam hz_ctrl_t HZ_MDU   = hz_ctrl_t'(6'b110101);

    // A source operand collides with E's destination; x0 never collides.
    function automatic logic src_hit(
        input logic       use_src,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return use_src && (rs != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// One saturating event counter for hazard statistics.
// Holds at all-ones; cleared by synchronous reset.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Count events, sticking at the maximum value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush sequencer for F/D/E/M pipeline registers.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       D_rs1_i,
    input  logic [4:0]       D_rs2_i,
    input  logic             D_use_rs1_i,
    input  logic             D_use_rs2_i,
    input  logic             DD_need_dstE_i,
    input  logic [4:0]       DD_dstE_i,
    input  logic             DD_sel_reg_i,
    input  logic             E_valid_i,
    input  logic             E_mdu_start_i,
    input  logic             mdu_done_i,
    input  logic             E_redirect_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_stall_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             mdu_timeout_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_ldu_o,
    output logic [CNT_W-1:0] perf_mdu_o,
    output logic [CNT_W-1:0] perf_flush_o
`endif
);

    localparam int CW = $clog2(MDU_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(MDU_TIMEOUT);

    hz_state_t     state_q;
    hz_state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    hz_ctrl_t      ctrl;
    logic          timeout;
    logic          ldu;

    // Load in E whose result a D source needs before the bypass can supply it.
    assign ldu = DD_need_dstE_i && !DD_sel_reg_i && E_valid_i &&
                 (src_hit(D_use_rs1_i, D_rs1_i, DD_dstE_i) ||
                  src_hit(D_use_rs2_i, D_rs2_i, DD_dstE_i));

    // Next state, wait counter and same-cycle pipeline controls.
    always_comb begin
        ctrl    = HZ_NONE;
        timeout = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst_i) begin
            ctrl    = HZ_RESET;
            state_d = HZ_RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    if (E_valid_i && E_mdu_start_i) begin
                        if (!mdu_done_i) begin
                            ctrl    = HZ_MDU;
                            state_d = HZ_MDU_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end else if (E_redirect_i) begin
                        ctrl = HZ_FLUSH;
                    end else if (ldu) begin
                        ctrl = HZ_LDU;
                    end
                end
                HZ_MDU_WAIT: begin
                    if (mdu_done_i) begin
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_CNT) begin
                        timeout = 1'b1;
                        state_d = HZ_RUN;
                        cnt_d   = '0;
                    end else begin
                        ctrl  = HZ_MDU;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and MDU wait counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign F_stall_o     = ctrl.f_stall;
    assign D_stall_o     = ctrl.d_stall;
    assign D_bubble_o    = ctrl.d_bubble;
    assign E_stall_o     = ctrl.e_stall;
    assign E_bubble_o    = ctrl.e_bubble;
    assign M_bubble_o    = ctrl.m_bubble;
    assign mdu_timeout_o = timeout;

`ifdef HAZARD_PERF_EN
    logic ev_ldu;
    logic ev_mdu;
    logic ev_flush;

    // E stall only comes from the MDU; D stall without it is a load-use.
    assign ev_mdu   = ctrl.e_stall;
    assign ev_ldu   = ctrl.d_stall && !ctrl.e_stall;
    assign ev_flush = ctrl.d_bubble && !rst_i;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_ldu (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ev_ldu),
        .cnt_o (perf_ldu_o)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mdu (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ev_mdu),
        .cnt_o (perf_mdu_o)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ev_flush),
        .cnt_o (perf_flush_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl against a behavioural model.
// Perf counter checks are active when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

    localparam int TO = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, dst = '0;
    logic       use1 = 0, use2 = 0, need = 0, selreg = 0;
    logic       ev = 0, mstart = 0, mdone = 0, redir = 0;

    logic f_st, d_st, d_bb, e_st, e_bb, m_bb, tmo;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] p_ldu, p_mdu, p_fl;
`endif

    hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .D_rs1_i        (rs1),
        .D_rs2_i        (rs2),
        .D_use_rs1_i    (use1),
        .D_use_rs2_i    (use2),
        .DD_need_dstE_i (need),
        .DD_dstE_i      (dst),
        .DD_sel_reg_i   (selreg),
        .E_valid_i      (ev),
        .E_mdu_start_i  (mstart),
        .mdu_done_i     (mdone),
        .E_redirect_i   (redir),
        .F_stall_o      (f_st),
        .D_stall_o      (d_st),
        .D_bubble_o     (d_bb),
        .E_stall_o      (e_st),
        .E_bubble_o     (e_bb),
        .M_bubble_o     (m_bb),
        .mdu_timeout_o  (tmo)
`ifdef HAZARD_PERF_EN
        ,
        .perf_ldu_o     (p_ldu),
        .perf_mdu_o     (p_mdu),
        .perf_flush_o   (p_fl)
`endif
    );

    typedef struct {
        logic [6:0] ctl;
        int         ldu;
        int         mdu;
        int         fl;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: MDU busy flag, cycles spent waiting, event tallies.
    bit busy = 0;
    int waited = 0;
    int n_ldu = 0, n_mdu = 0, n_fl = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Compute this cycle's expected response, queue it, advance one clock.
    task automatic tick();
        exp_t e;
        bit   hit;
        bit   fs, ds, db, es, eb, mb, to;
        e.ldu = sat(n_ldu);
        e.mdu = sat(n_mdu);
        e.fl  = sat(n_fl);
        e.cyc = cyc;
        {fs, ds, db, es, eb, mb, to} = 7'b0;
        hit = need && !selreg && ev &&
              ((use1 && rs1 != 0 && rs1 == dst) ||
               (use2 && rs2 != 0 && rs2 == dst));
        if (rst) begin
            db = 1; eb = 1; mb = 1;
            busy = 0; waited = 0;
            n_ldu = 0; n_mdu = 0; n_fl = 0;
        end else if (busy) begin
            if (mdone) begin
                busy = 0;
            end else if (waited == TO) begin
                to = 1;
                busy = 0;
            end else begin
                fs = 1; ds = 1; es = 1; mb = 1;
                waited++;
                n_mdu++;
            end
        end else if (ev && mstart) begin
            if (!mdone) begin
                fs = 1; ds = 1; es = 1; mb = 1;
                busy = 1;
                waited = 1;
                n_mdu++;
            end
        end else if (redir) begin
            db = 1; eb = 1;
            n_fl++;
        end else if (hit) begin
            fs = 1; ds = 1; eb = 1;
            n_ldu++;
        end
        e.ctl = {fs, ds, db, es, eb, mb, to};
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rst = 0; rs1 = 0; rs2 = 0; dst = 0;
        use1 = 0; use2 = 0; need = 0; selreg = 0;
        ev = 0; mstart = 0; mdone = 0; redir = 0;
    endtask

    task automatic set_ldu(input logic [4:0] r);
        idle();
        ev = 1; need = 1; selreg = 0; dst = r;
        use1 = 1; rs1 = r;
    endtask

    // Monitor: outputs are valid every cycle; pop and compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e = q.pop_front();
            got = {f_st, d_st, d_bb, e_st, e_bb, m_bb, tmo};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b",
                         e.cyc, got, e.ctl);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (p_ldu !== CW'(e.ldu) || p_mdu !== CW'(e.mdu) ||
                p_fl !== CW'(e.fl)) begin
                errors++;
                $display("FAIL perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         e.cyc, p_ldu, p_mdu, p_fl, e.ldu, e.mdu, e.fl);
            end
`endif
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset
        idle(); rst = 1; tick(); tick();
        idle(); tick();

        // Load-use on x5, then clean, then x0 never hazards
        set_ldu(5'd5); tick();
        idle(); tick();
        set_ldu(5'd0); tick();
        set_ldu(5'd5); use1 = 0; use2 = 1; rs2 = 5'd5; tick();
        set_ldu(5'd5); selreg = 1; tick();
        idle(); tick();

        // MDU op finishing after 4 cycles
        idle(); ev = 1; mstart = 1; tick();
        idle(); tick(); tick(); tick();
        mdone = 1; tick();
        idle(); tick();

        // Single-cycle MDU op
        idle(); ev = 1; mstart = 1; mdone = 1; tick();

        // Redirect together with load-use
        set_ldu(5'd7); redir = 1; tick();
        idle(); tick();

        // Timeout with no done; redirect/ldu ignored while waiting
        idle(); ev = 1; mstart = 1; tick();
        for (int i = 0; i < 10; i++) begin
            set_ldu(5'd3); redir = (i % 2 == 0); tick();
        end
        idle(); tick();

        // Reset in the middle of an MDU wait
        idle(); ev = 1; mstart = 1; tick();
        idle(); tick(); tick();
        rst = 1; tick();
        idle(); tick(); tick();

        // Many load-use events to saturate the perf counter
        for (int i = 0; i < 20; i++) begin
            set_ldu(5'(1 + (i % 31))); tick();
            idle(); tick();
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom_range(99) == 0);
            rs1    = 5'($urandom_range(3));
            rs2    = 5'($urandom_range(3));
            dst    = 5'($urandom_range(3));
            use1   = 1'($urandom_range(1));
            use2   = 1'($urandom_range(1));
            need   = 1'($urandom_range(1));
            selreg = 1'($urandom_range(1));
            ev     = ($urandom_range(3) != 0);
            mstart = ($urandom_range(9) == 0);
            mdone  = ($urandom_range(5) == 0);
            redir  = ($urandom_range(4) == 0);
            tick();
        end

        idle(); tick();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
